// File: rtl/sin_cos_table_arbiter.sv
// rtl/sin_cos_table_arbiter.sv - round-robin sharing of one sin_cos_table among NUM_REQ requesters
// Optional stall support via SIN_COS_ARB_STALL_EN (adds RESP_READY).
module sin_cos_table_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 13,
    parameter int LATENCY    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_PHASE,
`ifdef SIN_COS_ARB_STALL_EN
    input  logic                          RESP_READY,
`endif
    output logic [NUM_REQ-1:0]            GNT,
    output logic                          TBL_CE,
    output logic [ADDR_WIDTH-1:0]         TBL_PHASE,
    input  logic [DATA_WIDTH-1:0]         TBL_SIN,
    input  logic [DATA_WIDTH-1:0]         TBL_COS,
    output logic [NUM_REQ-1:0]            RESP_VALID,
    output logic [DATA_WIDTH-1:0]         RESP_SIN,
    output logic [DATA_WIDTH-1:0]         RESP_COS,
    output logic                          BUSY
);

    logic                  advance;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   winner;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] held_phase;
    logic [ADDR_WIDTH-1:0] phases [NUM_REQ];
    logic [LATENCY-1:0]    vpipe;
    logic [ID_WIDTH-1:0]   tpipe [LATENCY];

`ifdef SIN_COS_ARB_STALL_EN
    assign advance = RESP_READY;
`else
    assign advance = 1'b1;
`endif
    assign TBL_CE = advance;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            phases[i] = REQ_PHASE[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Search starts just past the last winner and wraps, giving rotating priority.
    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_WIDTH'((int'(ptr) + off) % NUM_REQ);
            if (!grant_any && REQ[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
        end
        if (!advance || !RESET_N) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        GNT = '0;
        if (grant_any) begin
            GNT[winner] = 1'b1;
        end
        TBL_PHASE = grant_any ? phases[winner] : held_phase;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr        <= ID_WIDTH'(NUM_REQ - 1);
            held_phase <= '0;
            vpipe      <= '0;
            for (int j = 0; j < LATENCY; j++) begin
                tpipe[j] <= '0;
            end
        end else if (advance) begin
            vpipe    <= {vpipe[LATENCY-2:0], grant_any};
            tpipe[0] <= winner;
            for (int j = 1; j < LATENCY; j++) begin
                tpipe[j] <= tpipe[j-1];
            end
            if (grant_any) begin
                ptr        <= winner;
                held_phase <= TBL_PHASE;
            end
        end
    end

    // Last pipe stage lines up with the table output for the same phase.
    always_comb begin
        RESP_VALID = '0;
        if (vpipe[LATENCY-1]) begin
            RESP_VALID[tpipe[LATENCY-1]] = 1'b1;
        end
    end

    assign RESP_SIN = TBL_SIN;
    assign RESP_COS = TBL_COS;
    assign BUSY     = |vpipe;

endmodule
